// File: rtl/debug_trace_tx_if.sv
// Byte-wide valid/ready stream carrying trace frames from debug_trace_tx to its consumer.
interface debug_trace_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/debug_trace_tx.sv
// Captures {pc, instr, alu} whenever the fetch PC changes, queues records in a small FIFO and
// streams each one out as a 12-byte frame: sync, pc, instr, alu high bits, alu, XOR checksum.
module debug_trace_tx #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trace_en,
    input  logic [7:0]              dbg_pc,
    input  logic [31:0]             dbg_instr,
    input  logic [33:0]             dbg_alu_out,
    debug_trace_tx_if.master        tx,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [7:0]              overflow_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = 74;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [RW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [7:0]    prev_pc;
    logic          prev_valid;
    logic [0:0]    state;
    logic [3:0]    idx;
    logic [RW-1:0] frame;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;

    logic          capture;
    logic          empty;
    logic          full;
    logic          accept;
    logic          last;
    logic          pop;
    logic          push;
    logic          drop;
    logic [3:0]    idx_nxt;
    logic [7:0]    next_byte;
    logic [7:0]    cksum;
    logic [7:0]    fr_pc;
    logic [31:0]   fr_instr;
    logic [33:0]   fr_alu;

    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (fifo_level == '0);
    assign full       = (fifo_level == FULL_LVL);

    assign capture = trace_en && (!prev_valid || (dbg_pc != prev_pc));
    assign accept  = tx_valid_q && tx.tx_ready;
    assign last    = accept && (idx == 4'd11);
    // A pop on the same edge frees a slot, so a full FIFO can still take the capture.
    assign pop     = !empty && ((state == ST_IDLE) || last);
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;

    assign fr_pc    = frame[73:66];
    assign fr_instr = frame[65:34];
    assign fr_alu   = frame[33:0];
    assign idx_nxt  = idx + 4'd1;

    always_comb begin
        cksum = fr_pc ^ fr_instr[31:24] ^ fr_instr[23:16] ^ fr_instr[15:8] ^ fr_instr[7:0]
              ^ {6'b0, fr_alu[33:32]}
              ^ fr_alu[31:24] ^ fr_alu[23:16] ^ fr_alu[15:8] ^ fr_alu[7:0];
    end

    always_comb begin
        next_byte = SYNC_BYTE;
        case (idx_nxt)
            4'd1:    next_byte = fr_pc;
            4'd2:    next_byte = fr_instr[31:24];
            4'd3:    next_byte = fr_instr[23:16];
            4'd4:    next_byte = fr_instr[15:8];
            4'd5:    next_byte = fr_instr[7:0];
            4'd6:    next_byte = {6'b0, fr_alu[33:32]};
            4'd7:    next_byte = fr_alu[31:24];
            4'd8:    next_byte = fr_alu[23:16];
            4'd9:    next_byte = fr_alu[15:8];
            4'd10:   next_byte = fr_alu[7:0];
            4'd11:   next_byte = cksum;
            default: next_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {dbg_pc, dbg_instr, dbg_alu_out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            prev_pc      <= 8'h00;
            prev_valid   <= 1'b0;
            overflow_cnt <= 8'h00;
        end else begin
            if (!trace_en) begin
                prev_valid <= 1'b0;
            end else if (capture) begin
                prev_pc    <= dbg_pc;
                prev_valid <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop && (overflow_cnt != 8'hFF)) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 4'd0;
            frame      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else if (pop) begin
            frame      <= mem[rd_ptr[AW-1:0]];
            state      <= ST_SEND;
            idx        <= 4'd0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
        end else if (last) begin
            state      <= ST_IDLE;
            idx        <= 4'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else if (accept) begin
            idx       <= idx_nxt;
            tx_data_q <= next_byte;
        end
    end
endmodule

// File: tb/tb_debug_trace_tx.sv
// Directed bench for debug_trace_tx: table of single-frame vectors plus hand-written sequences
// for back-to-back frames, jump-to-self, overflow and reset mid-frame.
module tb_debug_trace_tx;
    logic        clk;
    logic        rst_n;
    logic        trace_en;
    logic [7:0]  dbg_pc;
    logic [31:0] dbg_instr;
    logic [33:0] dbg_alu_out;
    logic [2:0]  fifo_level;
    logic [7:0]  overflow_cnt;

    debug_trace_tx_if tx_if ();

    debug_trace_tx #(
        .DEPTH     (4),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_en     (trace_en),
        .dbg_pc       (dbg_pc),
        .dbg_instr    (dbg_instr),
        .dbg_alu_out  (dbg_alu_out),
        .tx           (tx_if.master),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
        logic [33:0] alu;
        logic        bp;
        logic [95:0] frame;
    } vec_t;

    vec_t vecs [6];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Consumer state, written only by the consumer process.
    logic [7:0] rx [$];
    int         cyc         = 0;
    int         first_valid = -1;
    int         last_acc    = -1;
    int         gap_cnt     = 0;
    int         stab_viol   = 0;
    int         mid_drop    = 0;
    logic       prev_stall  = 1'b0;
    logic [7:0] prev_data   = 8'h00;
    logic       phase       = 1'b1;
    // Written only by the test process: 0 ready high, 1 toggle, 2 ready low.
    int         rdy_mode    = 0;
    int         gap_limit   = 0;

    initial begin
        tx_if.tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rx.delete();
                first_valid    = -1;
                last_acc       = -1;
                gap_cnt        = 0;
                prev_stall     = 1'b0;
                phase          = 1'b1;
                tx_if.tx_ready = 1'b0;
            end else begin
                if (prev_stall && (!tx_if.tx_valid || tx_if.tx_data !== prev_data)) stab_viol++;
                if (!tx_if.tx_valid && (rx.size() % 12) != 0) mid_drop++;
                if (!tx_if.tx_valid && rx.size() > 0 && rx.size() < gap_limit) gap_cnt++;
                if (rdy_mode == 0) begin
                    tx_if.tx_ready = 1'b1;
                end else if (rdy_mode == 1) begin
                    if (first_valid < 0 && !tx_if.tx_valid) begin
                        tx_if.tx_ready = 1'b0;
                    end else begin
                        tx_if.tx_ready = phase;
                        phase          = !phase;
                    end
                end else begin
                    tx_if.tx_ready = 1'b0;
                end
                if (tx_if.tx_valid && first_valid < 0) first_valid = cyc;
                if (tx_if.tx_valid && tx_if.tx_ready) begin
                    rx.push_back(tx_if.tx_data);
                    last_acc = cyc;
                end
                prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
                prev_data  = tx_if.tx_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [95:0] frame_at(input int base);
        logic [95:0] f = '0;
        for (int i = 0; i < 12; i++) f = {f[87:0], rx[base + i]};
        return f;
    endfunction

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (rx.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("byte wait", 96'(rx.size() >= n), 96'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        trace_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{8'h04, 32'h12345678, 34'h3_000000FF, 1'b0,
                    96'hA5_04_12_34_56_78_03_00_00_00_FF_F0};
        vecs[1] = '{8'h00, 32'h00000000, 34'h0_00000000, 1'b0,
                    96'hA5_00_00_00_00_00_00_00_00_00_00_00};
        vecs[2] = '{8'hFF, 32'hFFFFFFFF, 34'h3_FFFFFFFF, 1'b0,
                    96'hA5_FF_FF_FF_FF_FF_03_FF_FF_FF_FF_FC};
        vecs[3] = '{8'h3C, 32'hDEADBEEF, 34'h1_80000001, 1'b0,
                    96'hA5_3C_DE_AD_BE_EF_01_80_00_00_01_9E};
        vecs[4] = '{8'h08, 32'h00000013, 34'h2_00000010, 1'b0,
                    96'hA5_08_00_00_00_13_02_00_00_00_10_09};
        vecs[5] = '{8'h04, 32'h12345678, 34'h3_000000FF, 1'b1,
                    96'hA5_04_12_34_56_78_03_00_00_00_FF_F0};

        rst_n       = 1'b0;
        trace_en    = 1'b0;
        dbg_pc      = 8'h00;
        dbg_instr   = 32'h0;
        dbg_alu_out = 34'h0;
        #1;
        check("reset tx_valid", 96'(tx_if.tx_valid), 96'd0);
        check("reset tx_data", 96'(tx_if.tx_data), 96'h00);
        check("reset fifo_level", 96'(fifo_level), 96'd0);
        check("reset overflow_cnt", 96'(overflow_cnt), 96'd0);

        // Single-frame vectors, each from reset with inputs held constant.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            rdy_mode    = vecs[v].bp ? 1 : 0;
            gap_limit   = 0;
            dbg_pc      = vecs[v].pc;
            dbg_instr   = vecs[v].instr;
            dbg_alu_out = vecs[v].alu;
            trace_en    = 1'b1;
            @(negedge clk);
            check("latency valid after capture", 96'(tx_if.tx_valid), 96'd0);
            check("latency level after capture", 96'(fifo_level), 96'd1);
            @(negedge clk);
            check("latency valid after pop", 96'(tx_if.tx_valid), 96'd1);
            check("latency sync byte", 96'(tx_if.tx_data), 96'hA5);
            check("latency level after pop", 96'(fifo_level), 96'd0);
            wait_bytes(12, 100);
            check("vector frame", frame_at(0), vecs[v].frame);
            check("vector frame span", 96'(last_acc - first_valid + 1), vecs[v].bp ? 96'd23 : 96'd12);
            idle_cycles(30);
            check("vector single frame", 96'(rx.size()), 96'd12);
        end

        // Back-to-back: PC steps every 12 cycles.
        do_reset();
        rdy_mode    = 0;
        gap_limit   = 36;
        dbg_instr   = 32'h00000013;
        dbg_alu_out = 34'h2_00000010;
        dbg_pc      = 8'h00;
        trace_en    = 1'b1;
        repeat (12) @(negedge clk);
        dbg_pc = 8'h04;
        repeat (12) @(negedge clk);
        dbg_pc = 8'h08;
        wait_bytes(36, 200);
        idle_cycles(30);
        check("b2b byte count", 96'(rx.size()), 96'd36);
        check("b2b frame 0", frame_at(0), 96'hA5_00_00_00_00_13_02_00_00_00_10_01);
        check("b2b frame 1", frame_at(12), 96'hA5_04_00_00_00_13_02_00_00_00_10_05);
        check("b2b frame 2", frame_at(24), 96'hA5_08_00_00_00_13_02_00_00_00_10_09);
        check("b2b valid gaps", 96'(gap_cnt), 96'd0);
        gap_limit = 0;

        // Jump-to-self traced once; enable toggle retriggers capture.
        do_reset();
        rdy_mode    = 0;
        dbg_pc      = 8'h10;
        dbg_instr   = 32'h0;
        dbg_alu_out = 34'h0;
        trace_en    = 1'b1;
        idle_cycles(50);
        check("self-jump frames", 96'(rx.size()), 96'd12);
        check("self-jump frame", frame_at(0), 96'hA5_10_00_00_00_00_00_00_00_00_00_10);
        @(negedge clk);
        trace_en = 1'b0;
        @(negedge clk);
        trace_en = 1'b1;
        idle_cycles(40);
        check("re-enable frames", 96'(rx.size()), 96'd24);
        check("re-enable frame", frame_at(12), 96'hA5_10_00_00_00_00_00_00_00_00_00_10);

        // Overflow: consumer stalled, PC changes on 8 consecutive cycles.
        do_reset();
        rdy_mode    = 2;
        dbg_instr   = 32'h12345678;
        dbg_alu_out = 34'h3_000000FF;
        dbg_pc      = 8'h20;
        trace_en    = 1'b1;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            dbg_pc = 8'h20 + 8'(i);
        end
        @(negedge clk);
        check("overflow fifo_level", 96'(fifo_level), 96'd4);
        check("overflow count", 96'(overflow_cnt), 96'd3);
        check("overflow tx_valid held", 96'(tx_if.tx_valid), 96'd1);
        check("overflow tx_data held", 96'(tx_if.tx_data), 96'hA5);
        rdy_mode = 0;
        wait_bytes(60, 400);
        idle_cycles(30);
        check("overflow drained bytes", 96'(rx.size()), 96'd60);
        for (int k = 0; k < 5; k++) begin
            check("overflow frame pc", 96'(rx[12 * k + 1]), 96'(8'h20 + 8'(k)));
        end
        check("overflow level drained", 96'(fifo_level), 96'd0);
        check("overflow count kept", 96'(overflow_cnt), 96'd3);

        // Reset mid-frame, right after byte 5 is accepted.
        dbg_pc = 8'h44;
        wait_bytes(66, 100);
        check("pre-reset bytes", 96'({rx[60], rx[61], rx[62], rx[63], rx[64], rx[65]}),
              96'h00_00_00_00_00_00_A5_44_12_34_56_78);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset tx_valid", 96'(tx_if.tx_valid), 96'd0);
        check("async reset tx_data", 96'(tx_if.tx_data), 96'h00);
        check("async reset fifo_level", 96'(fifo_level), 96'd0);
        check("async reset overflow_cnt", 96'(overflow_cnt), 96'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_bytes(12, 100);
        check("post-reset frame", frame_at(0), 96'hA5_44_12_34_56_78_03_00_00_00_FF_B0);
        idle_cycles(30);
        check("post-reset single frame", 96'(rx.size()), 96'd12);

        check("hold stable while stalled", 96'(stab_viol), 96'd0);
        check("valid never drops mid-frame", 96'(mid_drop), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
